// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, branch/JAL/JALR redirects, one-outstanding
// imem request/response handshake and a single-entry output buffer toward decode.
module fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redir_valid,
  input  logic [1:0]      redir_mode,
  input  logic            redir_cond,
  input  logic [XLEN-1:0] redir_pc,
  input  logic [XLEN-1:0] redir_rs1,
  input  logic [XLEN-1:0] redir_imm,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            if_ready,
  output logic            misalign_err
);

  // state  | meaning
  // IDLE   | no request outstanding
  // WAIT   | one request outstanding, waiting for imem_rvalid
  // HALT   | misaligned redirect trapped; only reset leaves
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALT} state_t;

  localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] req_pc, req_pc_nxt;
  logic            drop, drop_nxt;
  logic            if_valid_nxt;
  logic [XLEN-1:0] if_pc_nxt, if_instr_nxt;
  logic            misalign_err_nxt;

  logic            taken;
  logic [XLEN-1:0] sum_pc, sum_rs, target;
  logic            misaligned;

  always_comb begin
    taken      = redir_valid & ((redir_mode == 2'b01) | (redir_mode == 2'b10) |
                                ((redir_mode == 2'b00) & redir_cond));
    sum_pc     = redir_pc + redir_imm;
    sum_rs     = redir_rs1 + redir_imm;
    target     = (redir_mode == 2'b10) ? (sum_rs & JALR_MASK) : sum_pc;
    misaligned = (target[1:0] != 2'b00);
  end

  assign imem_req  = (state == S_IDLE) & ~taken & (~if_valid | if_ready);
  assign imem_addr = fetch_pc;

  always_comb begin
    state_nxt        = state;
    fetch_pc_nxt     = fetch_pc;
    req_pc_nxt       = req_pc;
    drop_nxt         = drop;
    if_valid_nxt     = if_valid;
    if_pc_nxt        = if_pc;
    if_instr_nxt     = if_instr;
    misalign_err_nxt = misalign_err;

    if ((state != S_HALT) && taken) begin
      // A taken redirect overrides acceptance, response loading and draining.
      if_valid_nxt = 1'b0;
      if (misaligned) begin
        misalign_err_nxt = 1'b1;
        state_nxt        = S_HALT;
      end else begin
        fetch_pc_nxt = target;
        if (state == S_WAIT) begin
          if (imem_rvalid) state_nxt = S_IDLE;
          else             drop_nxt  = 1'b1;
        end
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (imem_req) begin
            req_pc_nxt   = fetch_pc;
            fetch_pc_nxt = fetch_pc + XLEN'(4);
            drop_nxt     = 1'b0;
            state_nxt    = S_WAIT;
          end
          if (if_valid & if_ready) if_valid_nxt = 1'b0;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_nxt = S_IDLE;
            if (!drop) begin
              if_valid_nxt = 1'b1;
              if_pc_nxt    = req_pc;
              if_instr_nxt = imem_rdata;
            end else if (if_valid & if_ready) begin
              if_valid_nxt = 1'b0;
            end
          end else if (if_valid & if_ready) begin
            if_valid_nxt = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      fetch_pc     <= RESET_VECTOR;
      req_pc       <= '0;
      drop         <= 1'b0;
      if_valid     <= 1'b0;
      if_pc        <= '0;
      if_instr     <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      fetch_pc     <= fetch_pc_nxt;
      req_pc       <= req_pc_nxt;
      drop         <= drop_nxt;
      if_valid     <= if_valid_nxt;
      if_pc        <= if_pc_nxt;
      if_instr     <= if_instr_nxt;
      misalign_err <= misalign_err_nxt;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage that replaces the fixed-width branch-only PC register. It generates the fetch PC, supports conditional branch, JAL and JALR redirects, talks to instruction memory over a request/response handshake with variable latency, and holds one fetched instruction in an output buffer with backpressure toward decode. It also detects misaligned redirect targets and halts fetch until reset.

## Interface
- XLEN, 32, address/data width
- RESET_VECTOR, {XLEN{1'b0}}, first fetch address after reset
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- redir_valid  in  1  redirect request from execute this cycle
- redir_mode  in  2  00 cond branch, 01 JAL, 10 JALR, 11 reserved (no effect)
- redir_cond  in  1  branch condition; used only for mode 00
- redir_pc  in  XLEN  PC of the redirecting instruction
- redir_rs1  in  XLEN  JALR base register value
- redir_imm  in  XLEN  sign-extended immediate
- imem_req  out  1  fetch request; accepted on the clk edge where it is high
- imem_addr  out  XLEN  fetch address, valid while imem_req=1
- imem_rvalid  in  1  response valid
- imem_rdata  in  XLEN  instruction word
- if_valid  out  1  output buffer holds an instruction
- if_pc  out  XLEN  PC of buffered instruction
- if_instr  out  XLEN  buffered instruction
- if_ready  in  1  decode consumes buffer on edge where if_valid&if_ready
- misalign_err  out  1  sticky: redirect target not 4-byte aligned

## Operation
- States: IDLE (no request outstanding), WAIT (one request outstanding), HALT (misalign trapped). At most one outstanding request.
- taken = redir_valid & (mode==01 | mode==10 | (mode==00 & redir_cond)). Not-taken branch and mode 11: no effect.
- target: modes 00/01 = redir_pc+redir_imm; mode 10 = (redir_rs1+redir_imm) with bit0 cleared. All sums are modulo 2^XLEN.
- imem_req = (state==IDLE) & ~taken & (~if_valid | if_ready). imem_addr = fetch_pc.
- On acceptance: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps 0xFFFFFFFC→0), state→WAIT, drop<=0.
- WAIT + imem_rvalid, drop=0, no taken: if_valid<=1, if_pc<=req_pc, if_instr<=imem_rdata, state→IDLE.
- WAIT + imem_rvalid with drop=1 or taken in the same cycle: response discarded, state→IDLE.
- imem_rvalid in IDLE or HALT is ignored.
- Taken redirect (any state except HALT), with target[1:0]==00: fetch_pc<=target, if_valid<=0, drop<=1 if in WAIT without rvalid this cycle. The redirect wins over every other event in the same cycle.
- Taken redirect with target[1:0]!=00: misalign_err<=1, if_valid<=0, state→HALT. No requests are issued afterwards and fetch_pc is not updated.
- Buffer drain: if_valid&if_ready with no new load clears if_valid. if_ready=0 holds if_pc and if_instr stable.

## Timing
- Reset values: fetch_pc=RESET_VECTOR, state=IDLE, if_valid=0, if_pc=0, if_instr=0, misalign_err=0, drop=0. imem_req therefore goes high in the first cycle after rst deasserts, with addr=RESET_VECTOR.
- imem_req is combinational from registered state plus the redirect and handshake inputs. All other outputs are registered.
- Latency: with a response one cycle after acceptance, if_valid rises 2 cycles after acceptance. Sustained throughput is 1 instruction per 2 cycles.
- The buffer never overflows: a request is issued only when the buffer is empty or draining, so the buffer is empty when the response arrives.
- Redirect latency: the first request to target is issued in the cycle after the redirect if state==IDLE. Otherwise it is issued in the cycle after the stale response returns.
- Asserting rst mid-operation drops any outstanding request immediately. A late response after reset arrives in IDLE and is ignored.

## Test plan
- Reset then sequential fetch, 1-cycle memory, if_ready=1: addresses 0,4,8,C; if_pc/if_instr match each address; if_valid pulses every 2nd cycle.
- RESET_VECTOR=32'hFFFFFFFC: first address FFFFFFFC, second 00000000 (wrap).
- Conditional branch: redir_pc=0x100, imm=0x20, cond=1 → next imem_addr=0x120, if_valid cleared. Same stimulus with cond=0 → sequential fetch continues.
- JALR rs1=0x203, imm=0x1 → target 0x204 (bit0 cleared). rs1=0x201, imm=0 → target 0x200. rs1=0x202, imm=0 → misalign_err=1, imem_req stays 0 until reset.
- Redirect while WAIT with 3-cycle memory latency: stale response discarded (no if_valid), next request goes to the target address. Redirect in the same cycle as imem_rvalid: response dropped.
- Backpressure: if_ready=0 for 5 cycles → if_pc/if_instr stable and no new imem_req. Then if_ready=1 → request issued in the same cycle.
